// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one row driven low per scan tick, debounced press/release.
// Events are registered one cycle after the accepting tick; there is no backpressure.
module keypad_scan #(
  parameter int SCAN_DIV       = 200000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int                 CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]         DB_TARGET = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HOLD,
    RELEASE_DB
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       row_idx, row_n;
  logic [1:0]       cap_col, col_n;
  logic [3:0]       db_cnt, db_n, db_inc;
  logic [3:0]       code_n;
  logic             valid_n, down_n;
  logic             any_low, cap_low;
  logic [1:0]       win_col;

  // Free-running row dwell timer; tick marks the sampling cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Lowest-index low column wins; scanning downward lets it overwrite higher ones.
  always_comb begin
    win_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_in[c]) begin
        win_col = 2'(c);
      end
    end
  end

  assign any_low = ~&col_in;
  assign cap_low = ~col_in[cap_col];
  assign db_inc  = (db_cnt >= DB_TARGET) ? DB_TARGET : db_cnt + 4'd1;

  always_comb begin
    state_n = state;
    row_n   = row_idx;
    col_n   = cap_col;
    db_n    = db_cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    down_n  = key_down;

    case (state)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            col_n = win_col;
            if (DB_TARGET <= 4'd1) begin
              code_n  = {row_idx, win_col};
              valid_n = 1'b1;
              down_n  = 1'b1;
              db_n    = 4'd0;
              state_n = HOLD;
            end else begin
              db_n    = 4'd1;
              state_n = PRESS_DB;
            end
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
      end

      PRESS_DB: begin
        if (tick) begin
          if (cap_low) begin
            if (db_inc >= DB_TARGET) begin
              code_n  = {row_idx, cap_col};
              valid_n = 1'b1;
              down_n  = 1'b1;
              db_n    = 4'd0;
              state_n = HOLD;
            end else begin
              db_n = db_inc;
            end
          end else begin
            db_n    = 4'd0;
            row_n   = row_idx + 2'd1;
            state_n = SCAN;
          end
        end
      end

      HOLD: begin
        // Only the captured column matters here; other keys cannot retrigger.
        if (tick && !cap_low) begin
          if (DB_TARGET <= 4'd1) begin
            down_n  = 1'b0;
            db_n    = 4'd0;
            row_n   = row_idx + 2'd1;
            state_n = SCAN;
          end else begin
            db_n    = 4'd1;
            state_n = RELEASE_DB;
          end
        end
      end

      RELEASE_DB: begin
        if (tick) begin
          if (!cap_low) begin
            if (db_inc >= DB_TARGET) begin
              down_n  = 1'b0;
              db_n    = 4'd0;
              row_n   = row_idx + 2'd1;
              state_n = SCAN;
            end else begin
              db_n = db_inc;
            end
          end else begin
            db_n    = 4'd0;
            state_n = HOLD;
          end
        end
      end

      default: begin
        state_n = SCAN;
        db_n    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      cap_col   <= 2'd0;
      db_cnt    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      row_idx   <= row_n;
      cap_col   <= col_n;
      db_cnt    <= db_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_down  <= down_n;
    end
  end

  assign row_out = ~(4'b0001 << row_idx);

endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench: directed scenarios plus random key activity against a tick-level model.
module tb_keypad_scan;

  localparam int DIV = 4;
  localparam int DB  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in = 4'hF;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one sample per tick, keypad seen as a 16-key press mask.
  int   m_cnt = 0, m_row = 0, m_col = 0, m_streak = 0, m_code = 0;
  bit   m_locked = 0, m_down = 0, m_valid = 0;
  logic [15:0] press_mask = '0;
  int   dut_pulses = 0;

  task automatic model_step();
    int found;
    if (rst) begin
      m_cnt = 0; m_row = 0; m_col = 0; m_streak = 0; m_code = 0;
      m_locked = 0; m_down = 0; m_valid = 0;
      return;
    end
    m_valid = 0;
    if (m_cnt == DIV - 1) begin
      if (!m_locked) begin
        found = -1;
        for (int c = 0; c < 4; c++)
          if (!col_in[c] && found < 0) found = c;
        if (found >= 0) begin
          m_locked = 1; m_col = found; m_streak = 1;
        end else begin
          m_row = (m_row + 1) % 4;
        end
        if (m_locked && m_streak >= DB) begin
          m_down = 1; m_valid = 1; m_code = m_row * 4 + m_col; m_streak = 0;
        end
      end else if (!m_down) begin
        if (!col_in[m_col]) begin
          m_streak++;
          if (m_streak >= DB) begin
            m_down = 1; m_valid = 1; m_code = m_row * 4 + m_col; m_streak = 0;
          end
        end else begin
          m_locked = 0; m_streak = 0; m_row = (m_row + 1) % 4;
        end
      end else begin
        if (col_in[m_col]) begin
          m_streak++;
          if (m_streak >= DB) begin
            m_down = 0; m_locked = 0; m_streak = 0; m_row = (m_row + 1) % 4;
          end
        end else begin
          m_streak = 0;
        end
      end
    end
    m_cnt = (m_cnt + 1) % DIV;
  endtask

  task automatic cyc();
    logic [3:0] exp_row;
    col_in = ~press_mask[m_row*4 +: 4];
    @(posedge clk);
    model_step();
    #1;
    exp_row = ~(4'b0001 << m_row);
    chk("row_out",   32'(row_out),   32'(exp_row));
    chk("key_code",  32'(key_code),  32'(m_code));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("key_down",  32'(key_down),  32'(m_down));
    if (key_valid === 1'b1) dut_pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_down(input string tag, input bit level);
    int budget = 200;
    while (m_down != level && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) chk(tag, 0, 1);
  endtask

  initial begin
    int budget;

    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // Idle scanning
    dut_pulses = 0;
    run(40);
    chk("idle_pulses", dut_pulses, 0);
    chk("idle_down", key_down, 0);

    // Clean press of row 2 col 1
    dut_pulses = 0;
    press_mask = 16'h0200;
    wait_down("press9_timeout", 1);
    run(2);
    chk("press9_pulses", dut_pulses, 1);
    chk("press9_code", key_code, 9);
    chk("press9_row", row_out, 4'b1011);
    press_mask = '0;
    wait_down("rel9_timeout", 0);
    run(1);
    chk("rel9_row", row_out, 4'b0111);
    chk("rel9_down", key_down, 0);

    // Press bounce on row 1 col 1
    dut_pulses = 0;
    press_mask = 16'h0020;
    budget = 200;
    while (!m_locked && budget > 0) begin cyc(); budget--; end
    if (budget == 0) chk("bounce_lock_timeout", 0, 1);
    press_mask = '0;
    budget = 200;
    while (m_locked && budget > 0) begin cyc(); budget--; end
    if (budget == 0) chk("bounce_unlock_timeout", 0, 1);
    chk("bounce_row", row_out, 4'b1011);
    run(20);
    chk("bounce_pulses", dut_pulses, 0);

    // Release bounce on row 1 col 2
    press_mask = 16'h0040;
    wait_down("relb_press_timeout", 1);
    dut_pulses = 0;
    press_mask = '0;
    run(2 * DIV);
    press_mask = 16'h0040;
    run(20);
    chk("relb_down_held", key_down, 1);
    chk("relb_pulses", dut_pulses, 0);
    press_mask = '0;
    wait_down("relb_release_timeout", 0);
    chk("relb_down_off", key_down, 0);
    chk("relb_pulses_end", dut_pulses, 0);

    // Multi-key in row 0, then an ignored key in row 3
    press_mask = 16'h000A;
    wait_down("multi_timeout", 1);
    run(1);
    chk("multi_code", key_code, 1);
    dut_pulses = 0;
    press_mask = press_mask | 16'h1000;
    run(40);
    chk("multi_ignored_pulses", dut_pulses, 0);
    chk("multi_code_held", key_code, 1);
    chk("multi_down", key_down, 1);
    press_mask = '0;
    wait_down("multi_release_timeout", 0);

    // Reset in the middle of press debounce
    press_mask = 16'h0200;
    budget = 200;
    while (!(m_locked && !m_down && m_streak == 2) && budget > 0) begin cyc(); budget--; end
    if (budget == 0) chk("rstmid_timeout", 0, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstmid_row", row_out, 4'b1110);
    chk("rstmid_valid", key_valid, 0);
    chk("rstmid_down", key_down, 0);
    chk("rstmid_code", key_code, 0);
    press_mask = '0;
    dut_pulses = 0;
    run(40);
    chk("rstmid_pulses", dut_pulses, 0);

    // Random key activity with bounce and occasional reset
    repeat (1500) begin
      if ($urandom_range(24) == 0) begin
        case ($urandom_range(3))
          0: press_mask = '0;
          1: press_mask = 16'(1) << $urandom_range(15);
          2: press_mask = (16'(1) << $urandom_range(15)) | (16'(1) << $urandom_range(15));
          default: press_mask = press_mask;
        endcase
      end
      if ($urandom_range(60) == 0) press_mask = press_mask ^ (16'(1) << $urandom_range(15));
      rst = ($urandom_range(399) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
